// File: rtl/camera_pwr_pkg.sv
// Shared definitions for the camera sensor power sequencer: state encodings,
// 24 MHz default delays and the timer width helper.
package camera_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_PWDN = 3'd1,
        ST_WAIT_RST  = 3'd2,
        ST_WAIT_INIT = 3'd3,
        ST_CONFIG    = 3'd4,
        ST_READY     = 3'd5,
        ST_SHUTDOWN  = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    localparam int T_PWDN_DEF    = 262144;
    localparam int T_RST_DEF     = 65535;
    localparam int T_INIT_DEF    = 1048575;
    localparam int T_OFF_DEF     = 4096;
    localparam int T_CFG_TO_DEF  = 4800000;
    localparam int MAX_RETRY_DEF = 2;

    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/camera_power_seq_timer.sv
// Per-state elapsed-cycle counter; flags the last cycle of a T-cycle wait and
// holds there so a lingering state cannot wrap it.
module seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] t,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (!done && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    // t == 0 means "no limit" (used for a disabled configuration timeout)
    assign done = (t != '0) && (cnt == t - CNT_W'(1));

endmodule

// File: rtl/camera_power_seq.sv
// Camera sensor power sequencer: PWDN/RESETB release, SCCB init supervision,
// bounded retries, controlled shutdown and a latched fault.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   OFF        | pins off, waiting for power_req
//   WAIT_PWDN  | supplies settling, PWDN still high
//   WAIT_RST   | PWDN low, RESETB held low
//   WAIT_INIT  | RESETB released, sensor booting
//   CONFIG     | SCCB master enabled, awaiting done/err/timeout
//   READY      | configured and streaming
//   SHUTDOWN   | RESETB low, PWDN low for T_OFF before going OFF
//   FAULT      | retries exhausted; left only by dropping power_req
module camera_power_seq
    import camera_pwr_pkg::*;
#(
    parameter int T_PWDN    = T_PWDN_DEF,
    parameter int T_RST     = T_RST_DEF,
    parameter int T_INIT    = T_INIT_DEF,
    parameter int T_OFF     = T_OFF_DEF,
    parameter int T_CFG_TO  = T_CFG_TO_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int CNT_W     = cnt_width(T_PWDN, T_RST, T_INIT, T_OFF, T_CFG_TO)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_req,
    input  logic       init_done,
    input  logic       init_err,
    output logic       camera_pwnd,
    output logic       camera_rstn,
    output logic       initial_en,
    output logic       ready,
    output logic       fault,
    output logic       busy,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] T_PWDN_C = CNT_W'(T_PWDN);
    localparam logic [CNT_W-1:0] T_RST_C  = CNT_W'(T_RST);
    localparam logic [CNT_W-1:0] T_INIT_C = CNT_W'(T_INIT);
    localparam logic [CNT_W-1:0] T_OFF_C  = CNT_W'(T_OFF);
    localparam logic [CNT_W-1:0] T_CFG_C  = CNT_W'(T_CFG_TO);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [3:0]       retry_nxt;
    logic [CNT_W-1:0] t_sel;
    logic             tmr_done;
    logic             tmr_clr;

    assign tmr_clr = (state_nxt != state);

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .t     (t_sel),
        .done  (tmr_done)
    );

    always_comb begin
        t_sel = '0;
        case (state)
            ST_WAIT_PWDN: t_sel = T_PWDN_C;
            ST_WAIT_RST:  t_sel = T_RST_C;
            ST_WAIT_INIT: t_sel = T_INIT_C;
            ST_CONFIG:    t_sel = T_CFG_C;
            ST_SHUTDOWN:  t_sel = T_OFF_C;
            default:      t_sel = '0;
        endcase
    end

    // Dropping power_req outranks every CONFIG event; error outranks done.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        case (state)
            ST_OFF: begin
                if (power_req) state_nxt = ST_WAIT_PWDN;
            end
            ST_WAIT_PWDN: begin
                if (!power_req)    state_nxt = ST_OFF;
                else if (tmr_done) state_nxt = ST_WAIT_RST;
            end
            ST_WAIT_RST: begin
                if (!power_req)    state_nxt = ST_SHUTDOWN;
                else if (tmr_done) state_nxt = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (!power_req)    state_nxt = ST_SHUTDOWN;
                else if (tmr_done) state_nxt = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (!power_req) begin
                    state_nxt = ST_SHUTDOWN;
                end else if (init_err || tmr_done) begin
                    if (retry_cnt < MAX_R) begin
                        retry_nxt = retry_cnt + 4'd1;
                        state_nxt = ST_SHUTDOWN;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end else if (init_done) begin
                    retry_nxt = '0;
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (!power_req) state_nxt = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (tmr_done) state_nxt = ST_OFF;
            end
            ST_FAULT: begin
                if (!power_req) begin
                    retry_nxt = '0;
                    state_nxt = ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // Pins are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_OFF;
            retry_cnt   <= '0;
            camera_pwnd <= 1'b1;
            camera_rstn <= 1'b0;
            initial_en  <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            retry_cnt   <= retry_nxt;
            camera_pwnd <= state_nxt inside {ST_OFF, ST_WAIT_PWDN, ST_FAULT};
            camera_rstn <= state_nxt inside {ST_WAIT_INIT, ST_CONFIG, ST_READY};
            initial_en  <= state_nxt inside {ST_CONFIG, ST_READY};
            ready       <= (state_nxt == ST_READY);
            fault       <= (state_nxt == ST_FAULT);
            busy        <= !(state_nxt inside {ST_OFF, ST_READY, ST_FAULT});
        end
    end

    assign state_o = state;

endmodule

// File: doc/camera_power_seq.md
Name: camera_power_seq

Overview:
Parametrised camera sensor power sequencer with cycle-count delays. On power-up it releases PWDN, then RESETB, then enables SCCB initialisation. It adds a controlled power-down sequence, supervision of the SCCB configuration (done, error and timeout), bounded automatic retries and a latched fault state. It sits between the board clock/reset and the SCCB configuration master, and drives the sensor PWDN and RESETB pins.

Parameters:
T_PWDN, 262144, cycles from power_req acceptance to PWDN low (about 10.9 ms at 24 MHz); must be at least 1
T_RST, 65535, cycles PWDN low before RESETB high; must be at least 1
T_INIT, 1048575, cycles RESETB high before initial_en asserts; must be at least 1
T_OFF, 4096, cycles RESETB low before PWDN high on shutdown; must be at least 1
T_CFG_TO, 4800000, configuration timeout in cycles; 0 disables the timeout
MAX_RETRY, 2, power-cycle retries after a configuration failure (0 to 15)
CNT_W, derived, $clog2 of the largest T_* value plus 1

Ports:
clk  in  1  system clock (24 MHz nominal)
reset  in  1  synchronous, active-high reset
power_req  in  1  level; 1 requests the camera on, 0 requests it off
init_done  in  1  one-cycle pulse from the SCCB master: configuration complete
init_err  in  1  one-cycle pulse from the SCCB master: NACK or configuration failure
camera_pwnd  out  1  sensor PWDN pin, active high
camera_rstn  out  1  sensor RESETB pin, active low
initial_en  out  1  level enable to the SCCB configuration master
ready  out  1  sensor configured and streaming
fault  out  1  retries exhausted; latched
busy  out  1  sequencing in progress (any state other than OFF, READY or FAULT)
retry_cnt  out  4  retries consumed since the last clean start
state_o  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered and update one cycle after the state transition.
- Reset values: camera_pwnd=1, camera_rstn=0, initial_en=0, ready=0, fault=0, busy=0, retry_cnt=0, state=OFF.
- Reset takes effect in any state and aborts sequencing immediately. The pins snap to the off state with no T_OFF wait.
- Timer: cleared on every state entry and incremented each cycle. A wait state with length T exits when cnt==T-1, so it lasts exactly T cycles.
- OFF (pwnd=1, rstn=0): power_req=1 moves to WAIT_PWDN.
- WAIT_PWDN (pwnd=1, rstn=0): after T_PWDN cycles moves to WAIT_RST.
- WAIT_RST (pwnd=0, rstn=0): after T_RST cycles moves to WAIT_INIT.
- WAIT_INIT (pwnd=0, rstn=1): after T_INIT cycles moves to CONFIG.
- CONFIG (initial_en=1):
  - init_done moves to READY.
  - init_err, or timer==T_CFG_TO-1 with T_CFG_TO nonzero, is a failure.
  - On failure with retry_cnt<MAX_RETRY: retry_cnt increments and the block moves to SHUTDOWN, then re-powers automatically.
  - On failure with retry_cnt==MAX_RETRY: moves to FAULT.
- READY (initial_en=1, ready=1): retry_cnt clears on entry. init_done and init_err are ignored.
- SHUTDOWN (pwnd=0, rstn=0, initial_en=0, ready=0): after T_OFF cycles moves to OFF.
- FAULT (pwnd=1, rstn=0, fault=1): the only exit is power_req=0, which moves to OFF and clears fault and retry_cnt.
- power_req=0 handling:
  - In WAIT_RST, WAIT_INIT, CONFIG or READY: moves to SHUTDOWN.
  - In WAIT_PWDN: moves directly to OFF.
  - power_req=0 takes priority over init_done, init_err and timeout in the same cycle.
- Same-cycle init_done and init_err: error wins.
- Entering OFF from SHUTDOWN with power_req=1 starts the next power-up on the following cycle, which is how retries proceed.
- power_req=1 arriving during SHUTDOWN is not honoured until SHUTDOWN completes, so T_OFF is never truncated.
- retry_cnt saturates at MAX_RETRY.
- State encoding: OFF=0, WAIT_PWDN=1, WAIT_RST=2, WAIT_INIT=3, CONFIG=4, READY=5, SHUTDOWN=6, FAULT=7.

Decomposition:
- Package camera_pwr_pkg holds:
  - the state localparams (3-bit encodings above);
  - default delay constants for 24 MHz;
  - the CNT_W derivation function.
- One sub-module, seq_timer: a CNT_W-bit up-counter.
  - Inputs: clr, plus a compare value T.
  - Output: a done flag when cnt==T-1.
  - It saturates and holds once done.
- The FSM, retry counter and output registers stay in camera_power_seq.

Test Plan:
All scenarios use T_PWDN=8, T_RST=4, T_INIT=6, T_OFF=3, T_CFG_TO=20, MAX_RETRY=1.
1. Release reset with power_req=1 held → pwnd falls 8 cycles after WAIT_PWDN entry, rstn rises 4 cycles later, initial_en rises 6 cycles after that. busy=1 throughout.
2. In CONFIG, pulse init_done → ready=1 next cycle and retry_cnt=0. Then drop power_req → rstn=0, ready=0, initial_en=0 next cycle, and pwnd=1 exactly 3 cycles later.
3. In CONFIG, pulse init_err → SHUTDOWN, OFF, full re-sequence, retry_cnt=1. A second init_err → FAULT with fault=1, pwnd=1, rstn=0. Then power_req=0 → fault=0, retry_cnt=0.
4. In CONFIG, give no response → failure declared after 20 cycles and a retry taken. Same run with T_CFG_TO=0 → stays in CONFIG indefinitely.
5. In CONFIG, pulse init_done together with power_req=0 in the same cycle → SHUTDOWN, ready never asserts. init_done and init_err together → treated as an error.
6. Assert reset in WAIT_INIT → next cycle pwnd=1, rstn=0, state=0, counters cleared. Separately, drop power_req during WAIT_PWDN → OFF directly with pwnd still 1.
